// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_AND    = 3'b010;
  localparam logic [2:0] OP_OR     = 3'b011;
  localparam logic [2:0] OP_XOR    = 3'b100;
  localparam logic [2:0] OP_ACC    = 3'b101;
  localparam logic [2:0] OP_CLRACC = 3'b110;
  localparam logic [2:0] OP_PASS   = 3'b111;

  // Flags vector is {N,Z,C,V}
  localparam logic [1:0] FLAG_N = 2'd3;
  localparam logic [1:0] FLAG_Z = 2'd2;
  localparam logic [1:0] FLAG_C = 2'd1;
  localparam logic [1:0] FLAG_V = 2'd0;

endpackage

// File: rtl/alu_addsub.sv
// Combinational add/subtract with carry, signed overflow and optional saturation.
module alu_addsub #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned SATURATE = 0
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] y_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] max_pos;
  logic [WIDTH-1:0] min_neg;

  // Subtraction is x + ~y + 1, so the carry out is the inverted borrow.
  always_comb begin
    y_eff   = sub_i ? ~y_i : y_i;
    sum     = {1'b0, x_i} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub_i};
    carry_o = sum[WIDTH];
    ovf_o   = (x_i[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x_i[WIDTH-1]);
    max_pos = {1'b0, {(WIDTH-1){1'b1}}};
    min_neg = {1'b1, {(WIDTH-1){1'b0}}};
    res_o   = sum[WIDTH-1:0];
    // On overflow the true result lies on the side given by the sign of x.
    if ((SATURATE != 0) && ovf_o) begin
      res_o = x_i[WIDTH-1] ? min_neg : max_pos;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Two-stage pipelined ALU with valid/ready handshake and a running accumulator.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] g,
  output logic [3:0]       flags
);

  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] g_q, g_d;
  logic [3:0]       flags_q, flags_d;

  logic             s2_adv;
  logic             accept;
  logic             move;
  logic [WIDTH-1:0] ar_x, ar_y;
  logic             ar_sub;
  logic [WIDTH-1:0] ar_res;
  logic             ar_c, ar_v;
  logic [WIDTH-1:0] res;
  logic [3:0]       res_flags;

  // Handshake: S2 advances unless its result is blocked; S1 accepts when it can drain.
  always_comb begin
    s2_adv   = !out_valid_q || out_ready;
    in_ready = !rst && (!s1_valid_q || s2_adv);
    accept   = in_valid && in_ready;
    move     = s1_valid_q && s2_adv;
  end

  // ACC adds the accumulator and a; other arithmetic uses a and b.
  always_comb begin
    ar_x   = (s1_op_q == OP_ACC) ? acc_q : s1_a_q;
    ar_y   = (s1_op_q == OP_ACC) ? s1_a_q : s1_b_q;
    ar_sub = (s1_op_q == OP_SUB);
  end

  alu_addsub #(
    .WIDTH   (WIDTH),
    .SATURATE(SATURATE)
  ) u_addsub (
    .x_i    (ar_x),
    .y_i    (ar_y),
    .sub_i  (ar_sub),
    .res_o  (ar_res),
    .carry_o(ar_c),
    .ovf_o  (ar_v)
  );

  // Result and flag decode for the operation sitting in S1.
  always_comb begin
    res       = '0;
    res_flags = '0;
    case (s1_op_q)
      OP_ADD, OP_SUB, OP_ACC: begin
        res               = ar_res;
        res_flags[FLAG_C] = ar_c;
        res_flags[FLAG_V] = ar_v;
      end
      OP_AND:    res = s1_a_q & s1_b_q;
      OP_OR:     res = s1_a_q | s1_b_q;
      OP_XOR:    res = s1_a_q ^ s1_b_q;
      OP_PASS:   res = s1_b_q;
      OP_CLRACC: res = '0;
      default:   res = '0;
    endcase
    res_flags[FLAG_N] = res[WIDTH-1];
    res_flags[FLAG_Z] = (res == '0);
  end

  // Next state for both stages and the accumulator.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    g_d         = g_q;
    flags_d     = flags_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_op_d    = op;
      s1_a_d     = a;
      s1_b_d     = b;
    end else if (move) begin
      s1_valid_d = 1'b0;
    end
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
    end
    if (move) begin
      g_d     = res;
      flags_d = res_flags;
      if (s1_op_q == OP_ACC) begin
        acc_d = ar_res;
      end else if (s1_op_q == OP_CLRACC) begin
        acc_d = '0;
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_ADD;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      g_q         <= '0;
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      g_q         <= g_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid = out_valid_q;
  assign g         = g_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench: three seq_alu variants driven in lockstep against a reference model.
module tb_seq_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [2:0]  op = OP_ADD;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  logic        rdy16, rdy3w, rdy3s;
  logic        ov16, ov3w, ov3s;
  logic [15:0] g16;
  logic [2:0]  g3w, g3s;
  logic [3:0]  f16, f3w, f3s;

  int tests = 0;
  int fails = 0;
  int ncyc = 0;
  bit ready_low_seen = 1'b0;

  logic [19:0] q16[$], q3w[$], q3s[$];
  logic [19:0] obs16[$], obs3w[$], obs3s[$];
  int          cyc16[$];
  logic [15:0] acc16 = '0, acc3w = '0, acc3s = '0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(16), .SATURATE(0)) d16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy16), .op(op), .a(a), .b(b),
    .out_valid(ov16), .out_ready(out_ready), .g(g16), .flags(f16)
  );
  seq_alu #(.WIDTH(3), .SATURATE(0)) d3w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3w), .op(op), .a(a[2:0]),
    .b(b[2:0]), .out_valid(ov3w), .out_ready(out_ready), .g(g3w), .flags(f3w)
  );
  seq_alu #(.WIDTH(3), .SATURATE(1)) d3s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3s), .op(op), .a(a[2:0]),
    .b(b[2:0]), .out_valid(ov3s), .out_ready(out_ready), .g(g3s), .flags(f3s)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic, returns {N,Z,C,V, result}.
  function automatic logic [19:0] model(input int w, input bit sat, input logic [2:0] o,
                                        input logic [15:0] ain, input logic [15:0] bin,
                                        inout logic [15:0] acc);
    longint m, half, ua, ub, x, y, sx, sy, ur, sr, r;
    bit c, v, n, z;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(ain) & m;
    ub   = longint'(bin) & m;
    x    = (o == OP_ACC) ? (longint'(acc) & m) : ua;
    y    = (o == OP_ACC) ? ua : ub;
    sx   = (x >= half) ? x - 2 * half : x;
    sy   = (y >= half) ? y - 2 * half : y;
    c = 1'b0; v = 1'b0; r = 0; ur = 0; sr = 0;
    case (o)
      OP_ADD, OP_ACC: begin ur = x + y; sr = sx + sy; c = (ur > m); end
      OP_SUB:         begin ur = x - y; sr = sx - sy; c = (x >= y); end
      default:        begin ur = 0; sr = 0; end
    endcase
    if (o inside {OP_ADD, OP_SUB, OP_ACC}) begin
      v = (sr > half - 1) || (sr < -half);
      if (sat && v) r = (sr > 0) ? half - 1 : half;
      else          r = ur & m;
    end else begin
      case (o)
        OP_AND:  r = ua & ub;
        OP_OR:   r = ua | ub;
        OP_XOR:  r = ua ^ ub;
        OP_PASS: r = ub;
        default: r = 0;
      endcase
    end
    if (o == OP_ACC) acc = r[15:0];
    else if (o == OP_CLRACC) acc = '0;
    n = r[w-1];
    z = (r == 0);
    return {n, z, c, v, r[15:0]};
  endfunction

  // Every cycle: outputs must equal the oldest outstanding expectation; accepts enqueue new ones.
  task automatic monitor();
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst) begin
        q16.delete(); q3w.delete(); q3s.delete();
        acc16 = '0; acc3w = '0; acc3s = '0;
        continue;
      end
      chk("ready_agree", {rdy3w, rdy3s}, {rdy16, rdy16});
      if (in_valid && !rdy16) ready_low_seen = 1'b1;
      if (ov16) begin
        chk("q16_nonempty", q16.size() > 0, 1);
        if (q16.size() > 0) begin
          chk("out16", {f16, g16}, q16[0]);
          if (out_ready) begin
            obs16.push_back({f16, g16}); cyc16.push_back(ncyc); q16.delete(0);
          end
        end
      end
      if (ov3w) begin
        chk("q3w_nonempty", q3w.size() > 0, 1);
        if (q3w.size() > 0) begin
          chk("out3w", {f3w, 13'd0, g3w}, q3w[0]);
          if (out_ready) begin obs3w.push_back({f3w, 13'd0, g3w}); q3w.delete(0); end
        end
      end
      if (ov3s) begin
        chk("q3s_nonempty", q3s.size() > 0, 1);
        if (q3s.size() > 0) begin
          chk("out3s", {f3s, 13'd0, g3s}, q3s[0]);
          if (out_ready) begin obs3s.push_back({f3s, 13'd0, g3s}); q3s.delete(0); end
        end
      end
      if (in_valid && rdy16) begin
        q16.push_back(model(16, 1'b0, op, a, b, acc16));
        q3w.push_back(model(3, 1'b0, op, a, b, acc3w));
        q3s.push_back(model(3, 1'b1, op, a, b, acc3s));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand set and hold it until accepted (bounded).
  task automatic push_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; op = o; a = x; b = y;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      ok = rdy16;
    end
    chk("accept_in_time", ok, 1);
    tick();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q16.size() != 0 || q3w.size() != 0 || q3s.size() != 0) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("drain", {q16.size(), q3w.size(), q3s.size()}, 0);
    tick();
  endtask

  task automatic clear_obs();
    obs16.delete(); obs3w.delete(); obs3s.delete(); cyc16.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] acc_exp [4];
    logic [15:0] bp_exp [4];
    acc_exp = '{16'd0, 16'd5, 16'd15, 16'd16};
    bp_exp  = '{16'd11, 16'd22, 16'd33, 16'd44};
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", ov16, 0);
    chk("rst_g", g16, 0);
    chk("rst_flags", f16, 0);
    chk("rst_in_ready", rdy16, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", rdy16, 1);
    tick();

    // Two back-to-back ADDs: result two cycles after presentation
    in_valid = 1'b1; op = OP_ADD; a = 16'd3; b = 16'd2;
    tick();
    a = 16'd1; b = 16'd6;
    @(negedge clk);
    chk("t1_not_early", ov16, 0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_res0", {ov16, f16, g16}, {1'b1, 4'b0000, 16'd5});
    tick();
    @(negedge clk);
    chk("t1_res1", {ov16, f16, g16}, {1'b1, 4'b0000, 16'd7});
    tick();
    @(negedge clk);
    chk("t1_idle", ov16, 0);
    tick();

    // 3-bit wrap and saturation corners
    clear_obs();
    push_op(OP_ADD, 16'd7, 16'd1);
    push_op(OP_ADD, 16'd3, 16'd1);
    push_op(OP_SUB, 16'd4, 16'd1);
    in_valid = 1'b0;
    drain();
    chk("t2_count", {obs3w.size(), obs3s.size()}, {32'd3, 32'd3});
    chk("t2_wrap_7p1", obs3w[0], {4'b0110, 16'd0});
    chk("t2_wrap_3p1", obs3w[1], {4'b1001, 16'd4});
    chk("t2_sat_3p1", obs3s[1], {4'b0001, 16'd3});
    chk("t2_sat_m4m1", obs3s[2], {4'b1011, 16'd4});

    // Accumulator chain, no bubbles
    clear_obs();
    push_op(OP_CLRACC, 16'd0, 16'd0);
    push_op(OP_ACC, 16'd5, 16'd0);
    push_op(OP_ACC, 16'd10, 16'd0);
    push_op(OP_ACC, 16'd1, 16'd0);
    in_valid = 1'b0;
    drain();
    chk("t3_count", obs16.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_acc%0d", i), obs16[i][15:0], acc_exp[i]);
    chk("t3_clr_flags", obs16[0][19:16], 4'b0100);
    chk("t3_burst", cyc16[3] - cyc16[0], 3);

    // Backpressure mid-stream
    clear_obs();
    ready_low_seen = 1'b0;
    fork
      begin
        push_op(OP_ADD, 16'd10, 16'd1);
        push_op(OP_ADD, 16'd20, 16'd2);
        push_op(OP_ADD, 16'd30, 16'd3);
        push_op(OP_ADD, 16'd40, 16'd4);
        in_valid = 1'b0;
      end
      begin
        tick();
        tick();
        out_ready = 1'b0;
        repeat (3) tick();
        out_ready = 1'b1;
      end
    join
    drain();
    chk("t4_ready_dropped", ready_low_seen, 1);
    chk("t4_count", obs16.size(), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("t4_res%0d", i), obs16[i][15:0], bp_exp[i]);

    // Reset with both stages full
    out_ready = 1'b0;
    push_op(OP_ADD, 16'd1, 16'd1);
    push_op(OP_ADD, 16'd2, 16'd2);
    in_valid = 1'b0;
    chk("t5_full_before_rst", {ov16, rdy16}, 2'b10);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_out_valid", ov16, 0);
    chk("t5_rst_g", g16, 0);
    chk("t5_rst_flags", f16, 0);
    chk("t5_rst_in_ready", rdy16, 0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t5_ready_after_rst", rdy16, 1);
    tick();
    clear_obs();
    push_op(OP_ACC, 16'd2, 16'd0);
    in_valid = 1'b0;
    drain();
    chk("t5_count", obs16.size(), 1);
    chk("t5_acc_after_rst", obs16[0], {4'b0000, 16'd2});

    repeat (3) tick();
    chk("final_ov_idle", {ov16, ov3w, ov3s}, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
